// File: rtl/any1_pkg.sv
// Shared reorder-buffer types: per-entry record, commit record and fault codes.
// Latency: none (types and constants only).
// Backpressure: none.
package any1_pkg;

    localparam int          ROB_ENTRIES = 32;
    localparam logic [15:0] FLT_NONE    = 16'h0000;

    // One ROB slot. ip is held at the widest supported address (64 bits);
    // the ROB narrows it back to AWID on the exception port.
    typedef struct packed {
        logic        v;
        logic        done;
        logic [63:0] ip;
        logic [63:0] ir;
        logic        rfwr;
        logic [7:0]  Rt;
        logic [63:0] res;
        logic [15:0] cause;
    } sRobEntry;

    // What one commit slot presents to the register-file write port.
    typedef struct packed {
        logic        v;
        logic        rfwr;
        logic [7:0]  Rt;
        logic [63:0] res;
    } sRobCommit;

endpackage

// File: rtl/any1_rob_ptr.sv
// Wrap-bit pointer helper: increment, rid-to-pointer mapping and "rid in [head,tail)" test.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ptr -> ptr_inc (ptr+1); rid is measured from head: rid_off (distance from head),
//        rid_inc (rid as a wrap-bit pointer, plus one), in_range (rid currently occupied).
module any1_rob_ptr #(
    parameter int RID_W = 5
) (
    input  logic [RID_W:0]   ptr,
    input  logic [RID_W:0]   head,
    input  logic [RID_W:0]   tail,
    input  logic [RID_W-1:0] rid,
    output logic [RID_W:0]   ptr_inc,
    output logic [RID_W:0]   rid_inc,
    output logic [RID_W-1:0] rid_off,
    output logic             in_range
);

    logic [RID_W:0] occ;
    logic [RID_W:0] rid_ptr;

    assign ptr_inc  = ptr + (RID_W+1)'(1);
    assign occ      = tail - head;
    // Distance of rid from head modulo the queue size; rid is live if that
    // distance is below the occupancy.
    assign rid_off  = rid - head[RID_W-1:0];
    assign in_range = {1'b0, rid_off} < occ;
    // Re-attach a wrap bit consistent with head so rid+1 can become a tail.
    assign rid_ptr  = head + {1'b0, rid_off};
    assign rid_inc  = rid_ptr + (RID_W+1)'(1);

endmodule

// File: rtl/any1_rob_mc.sv
// Reorder buffer: in-order alloc, out-of-order writeback, in-order commit of up to CMT_W/cycle,
// precise exception stop and partial mispredict flush. Latency: wb at edge n -> commit at edge n+1.
// Backpressure: alloc_rdy low when full or while flush_v is high; commit/exc outputs are 1-cycle pulses.
// Ports: alloc_* (decode side, rid returned on alloc_rid), wb_* (result write), flush_* (squash
//        younger than flush_rid), cmt_* (per-slot rf write, slot0 oldest), exc_* (fault), count/empty.
module any1_rob_mc
    import any1_pkg::*;
#(
    parameter  int ENTRIES = ROB_ENTRIES,
    parameter  int CMT_W   = 2,
    parameter  int AWID    = 32,
    localparam int RID_W   = $clog2(ENTRIES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_v,
    output logic                  alloc_rdy,
    input  logic [AWID-1:0]       alloc_ip,
    input  logic [63:0]           alloc_ir,
    input  logic                  alloc_rfwr,
    input  logic [7:0]            alloc_Rt,
    output logic [RID_W-1:0]      alloc_rid,
    input  logic                  wb_v,
    input  logic [RID_W-1:0]      wb_rid,
    input  logic [63:0]           wb_res,
    input  logic [15:0]           wb_cause,
    input  logic                  flush_v,
    input  logic [RID_W-1:0]      flush_rid,
    output logic [CMT_W-1:0]      cmt_v,
    output logic [CMT_W-1:0]      cmt_rfwr,
    output logic [CMT_W*8-1:0]    cmt_Rt,
    output logic [CMT_W*64-1:0]   cmt_res,
    output logic                  exc_v,
    output logic [15:0]           exc_cause,
    output logic [AWID-1:0]       exc_ip,
    output logic [RID_W:0]        count,
    output logic                  empty
);

    sRobEntry         rob [ENTRIES];
    logic [RID_W:0]   head, tail;
    logic [RID_W:0]   head_nxt, tail_nxt;
    logic [RID_W:0]   head_inc, tail_inc, tail_flush, occ;
    logic [RID_W-1:0] h0, h1, fl_off;
    logic             wb_ok, flush_ok, slot1_ok;
    logic             full, exc, flush_acc, alloc_fire;
    logic [1:0]       fire;
    sRobCommit        cmt_nxt [2];

    logic [RID_W-1:0] a_off, c_off;
    logic [RID_W:0]   a_inc, f_inc, c_inc;

    assign h0        = head[RID_W-1:0];
    assign h1        = h0 + RID_W'(1);
    assign occ       = tail - head;
    assign full      = (occ == (RID_W+1)'(ENTRIES));
    assign count     = occ;
    assign empty     = (occ == '0);
    assign alloc_rdy = !full && !flush_v;
    assign alloc_rid = tail[RID_W-1:0];

    // Tail increment for alloc; its range test also qualifies writeback rids.
    any1_rob_ptr #(.RID_W(RID_W)) u_alloc (
        .ptr      (tail),
        .head     (head),
        .tail     (tail),
        .rid      (wb_rid),
        .ptr_inc  (tail_inc),
        .rid_inc  (a_inc),
        .rid_off  (a_off),
        .in_range (wb_ok)
    );

    // Flush range check and the new tail (flush_rid + 1 with recomputed wrap bit).
    any1_rob_ptr #(.RID_W(RID_W)) u_flush (
        .ptr      (tail),
        .head     (head),
        .tail     (tail),
        .rid      (flush_rid),
        .ptr_inc  (f_inc),
        .rid_inc  (tail_flush),
        .rid_off  (fl_off),
        .in_range (flush_ok)
    );

    // Head advance and "second-oldest entry exists" for commit slot 1.
    any1_rob_ptr #(.RID_W(RID_W)) u_cmt (
        .ptr      (head),
        .head     (head),
        .tail     (tail),
        .rid      (h1),
        .ptr_inc  (head_inc),
        .rid_inc  (c_inc),
        .rid_off  (c_off),
        .in_range (slot1_ok)
    );

    logic unused_ptr;
    assign unused_ptr = ^{a_off, a_inc, f_inc, c_off, c_inc};

    // ir and the upper ip bits ride along for debug/trace only.
    logic unused_rob;
    always_comb begin
        unused_rob = 1'b0;
        for (int i = 0; i < ENTRIES; i++)
            unused_rob = unused_rob ^ (^rob[i].ir) ^ (^rob[i].ip);
    end

    always_comb begin
        exc        = rob[h0].v && rob[h0].done && (rob[h0].cause != FLT_NONE);
        flush_acc  = flush_v && flush_ok && !exc;
        alloc_fire = alloc_v && alloc_rdy && !exc;

        fire    = '0;
        fire[0] = rob[h0].v && rob[h0].done && (rob[h0].cause == FLT_NONE);
        // Slot 1 must not retire an entry that a same-edge flush at head squashes.
        if (CMT_W == 2)
            fire[1] = fire[0] && slot1_ok && rob[h1].v && rob[h1].done &&
                      (rob[h1].cause == FLT_NONE) && !(flush_acc && (fl_off == '0));

        cmt_nxt[0] = '{v: fire[0], rfwr: fire[0] && rob[h0].rfwr,
                       Rt: fire[0] ? rob[h0].Rt : 8'h00, res: fire[0] ? rob[h0].res : 64'h0};
        cmt_nxt[1] = '{v: fire[1], rfwr: fire[1] && rob[h1].rfwr,
                       Rt: fire[1] ? rob[h1].Rt : 8'h00, res: fire[1] ? rob[h1].res : 64'h0};

        if (fire[1])
            head_nxt = head_inc + (RID_W+1)'(1);
        else if (fire[0])
            head_nxt = head_inc;
        else
            head_nxt = head;

        // Exception empties the queue in place; flush and alloc are mutually
        // exclusive because alloc_rdy is low whenever flush_v is high.
        if (exc)
            tail_nxt = head;
        else if (flush_acc)
            tail_nxt = tail_flush;
        else if (alloc_fire)
            tail_nxt = tail_inc;
        else
            tail_nxt = tail;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head      <= '0;
            tail      <= '0;
            for (int i = 0; i < ENTRIES; i++)
                rob[i] <= '0;
            cmt_v     <= '0;
            cmt_rfwr  <= '0;
            cmt_Rt    <= '0;
            cmt_res   <= '0;
            exc_v     <= 1'b0;
            exc_cause <= '0;
            exc_ip    <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;

            // Writeback first; a later v clear on the same entry (flush/exception)
            // still wins, which discards wb to squashed rids.
            if (wb_v && wb_ok && rob[wb_rid].v) begin
                rob[wb_rid].done  <= 1'b1;
                rob[wb_rid].res   <= wb_res;
                rob[wb_rid].cause <= wb_cause;
            end

            if (fire[0]) rob[h0].v <= 1'b0;
            if (fire[1]) rob[h1].v <= 1'b0;

            for (int i = 0; i < ENTRIES; i++) begin
                if (exc)
                    rob[i].v <= 1'b0;
                else if (flush_acc && ((RID_W'(i) - h0) > fl_off))
                    rob[i].v <= 1'b0;
            end

            if (alloc_fire)
                rob[tail[RID_W-1:0]] <= '{v: 1'b1, done: 1'b0, ip: 64'(alloc_ip), ir: alloc_ir,
                                         rfwr: alloc_rfwr, Rt: alloc_Rt, res: 64'h0,
                                         cause: FLT_NONE};

            for (int k = 0; k < CMT_W; k++) begin
                cmt_v[k]           <= cmt_nxt[k].v;
                cmt_rfwr[k]        <= cmt_nxt[k].rfwr;
                cmt_Rt[k*8 +: 8]   <= cmt_nxt[k].Rt;
                cmt_res[k*64 +: 64] <= cmt_nxt[k].res;
            end

            exc_v     <= exc;
            exc_cause <= exc ? rob[h0].cause : 16'h0;
            exc_ip    <= exc ? rob[h0].ip[AWID-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_any1_rob_mc.sv
// Bench for any1_rob_mc: directed scenarios followed by random traffic, every cycle
// compared against a queue-based model of the ROB (oldest entry at index 0).
// Inputs change #1 after the rising edge; outputs are sampled #1 after the edge.
module tb_any1_rob_mc;

    localparam int ENT = 32;
    localparam int RW  = 5;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          alloc_v;
    logic          alloc_rdy;
    logic [31:0]   alloc_ip;
    logic [63:0]   alloc_ir;
    logic          alloc_rfwr;
    logic [7:0]    alloc_Rt;
    logic [RW-1:0] alloc_rid;
    logic          wb_v;
    logic [RW-1:0] wb_rid;
    logic [63:0]   wb_res;
    logic [15:0]   wb_cause;
    logic          flush_v;
    logic [RW-1:0] flush_rid;
    logic [1:0]    cmt_v, cmt_rfwr;
    logic [15:0]   cmt_Rt;
    logic [127:0]  cmt_res;
    logic          exc_v;
    logic [15:0]   exc_cause;
    logic [31:0]   exc_ip;
    logic [RW:0]   count;
    logic          empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    any1_rob_mc #(.ENTRIES(ENT), .CMT_W(2), .AWID(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .alloc_v(alloc_v), .alloc_rdy(alloc_rdy), .alloc_ip(alloc_ip), .alloc_ir(alloc_ir),
        .alloc_rfwr(alloc_rfwr), .alloc_Rt(alloc_Rt), .alloc_rid(alloc_rid),
        .wb_v(wb_v), .wb_rid(wb_rid), .wb_res(wb_res), .wb_cause(wb_cause),
        .flush_v(flush_v), .flush_rid(flush_rid),
        .cmt_v(cmt_v), .cmt_rfwr(cmt_rfwr), .cmt_Rt(cmt_Rt), .cmt_res(cmt_res),
        .exc_v(exc_v), .exc_cause(exc_cause), .exc_ip(exc_ip),
        .count(count), .empty(empty)
    );

    typedef struct {
        int          rid;
        bit          done;
        logic [63:0] res;
        logic [15:0] cause;
        logic [7:0]  rt;
        bit          rfwr;
        logic [31:0] ip;
    } ent_t;

    ent_t mq[$];
    int   tail_rid;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        alloc_v = 0; wb_v = 0; flush_v = 0;
        wb_rid = '0; wb_res = '0; wb_cause = '0; flush_rid = '0;
    endtask

    task automatic set_payload();
        alloc_ip   = $urandom;
        alloc_ir   = {$urandom, $urandom};
        alloc_rfwr = 1'($urandom_range(0, 1));
        alloc_Rt   = 8'($urandom_range(0, 255));
    endtask

    // One clock: check alloc_rdy, step the model over the edge, compare outputs.
    task automatic cycle();
        bit           rdy;
        int           fl_pos, n;
        logic [1:0]   e_v, e_rfwr;
        logic [15:0]  e_rt, m_rt;
        logic [127:0] e_res, m_res;
        logic         e_exc;
        logic [15:0]  e_cause;
        logic [31:0]  e_ip;
        ent_t         ne;
        #1;
        rdy = (mq.size() < ENT) && !flush_v;
        chk("alloc_rdy", alloc_rdy, rdy);
        e_v = 0; e_rfwr = 0; e_rt = 0; e_res = 0; e_exc = 0; e_cause = 0; e_ip = 0;
        if (mq.size() > 0 && mq[0].done && mq[0].cause != 0) begin
            e_exc = 1; e_cause = mq[0].cause; e_ip = mq[0].ip;
            tail_rid = mq[0].rid;
            mq.delete();
        end else begin
            fl_pos = -1;
            if (flush_v)
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].rid == int'(flush_rid)) fl_pos = i;
            n = 0;
            if (mq.size() > 0 && mq[0].done) n = 1;
            if (n == 1 && mq.size() > 1 && mq[1].done && mq[1].cause == 0 && fl_pos != 0) n = 2;
            for (int k = 0; k < n; k++) begin
                e_v[k] = 1; e_rfwr[k] = mq[k].rfwr;
                e_rt[k*8 +: 8] = mq[k].rt; e_res[k*64 +: 64] = mq[k].res;
            end
            if (wb_v)
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].rid == int'(wb_rid) && (fl_pos < 0 || i <= fl_pos)) begin
                        mq[i].done = 1; mq[i].res = wb_res; mq[i].cause = wb_cause;
                    end
            if (fl_pos >= 0) begin
                while (mq.size() > fl_pos + 1) void'(mq.pop_back());
                tail_rid = (int'(flush_rid) + 1) % ENT;
            end
            repeat (n) void'(mq.pop_front());
            if (alloc_v && rdy) begin
                ne = '{rid: tail_rid, done: 0, res: 0, cause: 0, rt: alloc_Rt, rfwr: alloc_rfwr, ip: alloc_ip};
                mq.push_back(ne);
                tail_rid = (tail_rid + 1) % ENT;
            end
        end
        @(posedge clk);
        #1;
        m_rt  = {{8{e_v[1]}}, {8{e_v[0]}}};
        m_res = {{64{e_v[1]}}, {64{e_v[0]}}};
        chk("cmt_v", cmt_v, e_v);
        chk("cmt_rfwr", cmt_rfwr & e_v, e_rfwr);
        chk("cmt_Rt", cmt_Rt & m_rt, e_rt);
        chk("cmt_res", cmt_res & m_res, e_res);
        chk("exc_v", exc_v, e_exc);
        if (e_exc) begin
            chk("exc_cause", exc_cause, e_cause);
            chk("exc_ip", exc_ip, e_ip);
        end
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("alloc_rid", alloc_rid, tail_rid);
    endtask

    task automatic do_reset();
        idle_in();
        rst_ni = 0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_cmt_v", cmt_v, 0);
        chk("rst_cmt_data", {cmt_rfwr, cmt_Rt, cmt_res[95:0]}, 0);
        chk("rst_exc", {exc_v, exc_cause, exc_ip}, 0);
        chk("rst_alloc_rid", alloc_rid, 0);
        mq.delete();
        tail_rid = 0;
        @(posedge clk);
        #1;
        rst_ni = 1;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_v = 1; set_payload(); cycle();
        end
        alloc_v = 0;
    endtask

    task automatic wb1(input int rid, input logic [63:0] res, input logic [15:0] cause);
        wb_v = 1; wb_rid = RW'(rid); wb_res = res; wb_cause = cause;
        cycle();
        wb_v = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Write back every outstanding entry until the queue is empty (bounded).
    task automatic drain();
        for (int g = 0; g < 200 && mq.size() > 0; g++) begin
            wb_v = 0;
            for (int i = 0; i < mq.size(); i++)
                if (!mq[i].done && !wb_v) begin
                    wb_v = 1; wb_rid = RW'(mq[i].rid); wb_res = {$urandom, $urandom}; wb_cause = 0;
                end
            cycle();
        end
        idle_in();
        idle(2);
        chk("drained", mq.size(), 0);
    endtask

    initial begin
        rst_ni = 0;
        alloc_ip = 0; alloc_ir = 0; alloc_rfwr = 0; alloc_Rt = 0;
        idle_in();
        do_reset();

        // Fill to full, then alloc held high while two commits free space.
        alloc_n(32);
        chk("full_count", count, 32);
        chk("full_rdy", alloc_rdy, 0);
        alloc_v = 1; set_payload();
        wb1(0, 64'h100, 0);
        wb1(1, 64'h101, 0);
        idle(3);
        alloc_v = 0;
        drain();

        // Out-of-order writeback, in-order paired commit.
        do_reset();
        alloc_n(4);
        wb1(3, 30, 0); wb1(1, 10, 0); wb1(2, 20, 0); wb1(0, 0, 0);
        idle(3);

        // Fault on rid1: rid0 commits, then the exception empties the ROB.
        do_reset();
        alloc_n(3);
        wb1(0, 64'hA, 0);
        wb1(1, 64'hB, 16'h0037);
        idle(3);
        chk("exc_empty", count, 0);

        // Flush keeping rids 0..2 while rid4 is written back on the same edge.
        do_reset();
        alloc_n(6);
        flush_v = 1; flush_rid = 2; wb_v = 1; wb_rid = 4; wb_res = 64'h44; wb_cause = 0;
        cycle();
        idle_in();
        chk("flush_count", count, 3);
        chk("flush_tail", alloc_rid, 3);
        drain();

        // Flush to an unoccupied rid is ignored.
        do_reset();
        alloc_n(4);
        flush_v = 1; flush_rid = 7;
        cycle();
        idle_in();
        chk("flush_ign", count, 4);
        drain();

        // Reset with completed-but-uncommitted work outstanding.
        do_reset();
        alloc_n(10);
        wb_v = 1; wb_rid = 0; wb_res = 1; wb_cause = 0;
        #1;
        do_reset();
        idle(4);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            alloc_v = ($urandom_range(0, 9) < 6);
            set_payload();
            wb_v = ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                wb_rid = RW'(mq[$urandom_range(0, mq.size() - 1)].rid);
            else
                wb_rid = RW'($urandom_range(0, ENT - 1));
            wb_res   = {$urandom, $urandom};
            wb_cause = ($urandom_range(0, 39) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
            flush_v  = ($urandom_range(0, 19) == 0);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                flush_rid = RW'(mq[$urandom_range(0, mq.size() - 1)].rid);
            else
                flush_rid = RW'($urandom_range(0, ENT - 1));
            cycle();
        end
        idle_in();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
